// File: rtl/peaks_sequencer.sv
// Pulses peaks once per FFT frame, captures {time, peaks} into a record FIFO, streams one peak per beat.
// Latency: fft_valid to fifo_level = PULSE_HIGH+SETTLE+2 cycles; a full FIFO drops captures, and rd_valid holds until rd_ready.
module peaks_sequencer #(
  parameter int PULSE_HIGH = 2,
  parameter int SETTLE     = 4,
  parameter int DEPTH      = 8,
  parameter int NPEAKS     = 6,
  parameter int AW         = 16,
  parameter int FW         = 9,
  parameter int TW         = 16
) (
  input  logic                        CLOCK_50,
  input  logic                        reset,
  input  logic                        fft_valid,
  output logic                        busy,
  output logic                        peaks_valid_in,
  input  logic [TW-1:0]               pk_counter,
  input  logic [AW*NPEAKS-1:0]        pk_ampl,
  input  logic [FW*NPEAKS-1:0]        pk_freq,
  output logic                        rd_valid,
  input  logic                        rd_ready,
  output logic [TW-1:0]               rd_time,
  output logic [$clog2(NPEAKS)-1:0]   rd_idx,
  output logic [FW-1:0]               rd_freq,
  output logic [AW-1:0]               rd_ampl,
  output logic                        rd_last,
  output logic [$clog2(DEPTH):0]      fifo_level,
  output logic [15:0]                 overrun_cnt,
  output logic [15:0]                 drop_cnt
);

  localparam int IW = $clog2(NPEAKS);
  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;
  localparam int CW = $clog2(PULSE_HIGH + SETTLE + 1);
  localparam int RW = TW + FW*NPEAKS + AW*NPEAKS;

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_PULSE   = 2'd1;
  localparam logic [1:0] S_SETTLE  = 2'd2;
  localparam logic [1:0] S_CAPTURE = 2'd3;

  logic [1:0]    state;
  logic [CW-1:0] cnt;

  logic [RW-1:0] mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [LW-1:0] level;

  logic                   capture;
  logic                   push;
  logic                   pop;
  logic                   beat;
  logic [RW-1:0]          head;
  logic [FW*NPEAKS-1:0]   head_freq;
  logic [AW*NPEAKS-1:0]   head_ampl;

  assign busy       = (state != S_IDLE);
  assign capture    = (state == S_CAPTURE);
  assign rd_valid   = (level != '0);
  assign rd_last    = rd_valid && (rd_idx == IW'(NPEAKS-1));
  assign beat       = rd_valid && rd_ready;
  assign pop        = beat && rd_last;
  // A full FIFO still accepts the capture when the head record leaves in the same cycle.
  assign push       = capture && ((level < LW'(DEPTH)) || pop);
  assign fifo_level = level;

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state          <= S_IDLE;
      cnt            <= '0;
      peaks_valid_in <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (fft_valid) begin
            state          <= S_PULSE;
            peaks_valid_in <= 1'b1;
            cnt            <= '0;
          end
        end
        S_PULSE: begin
          if (cnt == CW'(PULSE_HIGH-1)) begin
            state          <= S_SETTLE;
            peaks_valid_in <= 1'b0;
            cnt            <= '0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        S_SETTLE: begin
          if (cnt == CW'(SETTLE-1)) state <= S_CAPTURE;
          else                      cnt   <= cnt + CW'(1);
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      overrun_cnt <= '0;
      drop_cnt    <= '0;
    end else begin
      if (fft_valid && busy && (overrun_cnt != 16'hFFFF))
        overrun_cnt <= overrun_cnt + 16'd1;
      if (capture && !push && (drop_cnt != 16'hFFFF))
        drop_cnt <= drop_cnt + 16'd1;
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (push) mem[wr_ptr] <= {pk_counter, pk_freq, pk_ampl};
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      rd_idx <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
      if (beat) rd_idx <= rd_last ? '0 : rd_idx + IW'(1);
    end
  end

  assign head      = mem[rd_ptr];
  assign rd_time   = head[RW-1 -: TW];
  assign head_freq = head[AW*NPEAKS +: FW*NPEAKS];
  assign head_ampl = head[0 +: AW*NPEAKS];

  always_comb begin
    rd_freq = '0;
    rd_ampl = '0;
    for (int i = 0; i < NPEAKS; i++) begin
      if (rd_idx == IW'(i)) begin
        rd_freq = head_freq[i*FW +: FW];
        rd_ampl = head_ampl[i*AW +: AW];
      end
    end
  end

endmodule
